imm_decode_pipe: RTL

- Parametrised, pipelined successor to the combinational immediate generator.
- Accepts full 32-bit RV32/RV64 instructions over a valid/ready handshake and decodes the opcode to pick the immediate format.
- Produces one sign-extended XLEN-wide immediate, a format code and an illegal flag through 1 or 2 elastic register stages.
- Sits between fetch and the ALU/branch operand muxes of the next-generation OTTER datapath.

---
 rtl/immgen_pkg.sv | 89 ++++++++
 rtl/imm_stage_reg.sv | 45 ++++
 rtl/imm_decode_pipe.sv | 67 ++++++
 3 files changed

// File: rtl/immgen_pkg.sv
// Shared types, opcodes and the combinational immediate decoder.
// Optional feature: define IMMGEN_ZIMM_EN to decode CSR*I zero-extended immediates as FMT_Z.
package immgen_pkg;

    localparam int unsigned IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
    } imm_dec_t;

    // Immediate is produced at full 64-bit width; narrower datapaths keep the low bits.
    function automatic imm_dec_t decode_imm(input logic [31:0] instr);
        imm_dec_t             d;
        logic [IMM_MAX_W-1:0] sx;
        sx        = {IMM_MAX_W{instr[31]}};
        d.imm     = '0;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {sx[IMM_MAX_W-1:32], instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                d.fmt = FMT_J;
                d.imm = {sx[IMM_MAX_W-1:21], instr[31], instr[19:12], instr[20], instr[30:21],
                         1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                d.fmt = FMT_I;
                d.imm = {sx[IMM_MAX_W-1:12], instr[31:20]};
            end
            OPC_SYSTEM: begin
`ifdef IMMGEN_ZIMM_EN
                if (instr[14]) begin
                    d.fmt = FMT_Z;
                    d.imm = IMM_MAX_W'(instr[19:15]);
                end else begin
                    d.fmt = FMT_I;
                    d.imm = {sx[IMM_MAX_W-1:12], instr[31:20]};
                end
`else
                d.fmt = FMT_I;
                d.imm = {sx[IMM_MAX_W-1:12], instr[31:20]};
`endif
            end
            OPC_STORE: begin
                d.fmt = FMT_S;
                d.imm = {sx[IMM_MAX_W-1:12], instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {sx[IMM_MAX_W-1:13], instr[31], instr[7], instr[30:25], instr[11:8],
                         1'b0};
            end
            OPC_OP: begin
                d.fmt = FMT_NONE;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_stage_reg.sv
// One elastic pipeline register: valid bit plus payload, with a combinational ready chain.
module imm_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q;

    // Loadable when empty or when the current entry leaves this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (in_valid_i && in_ready_o) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Pipelined RV32/RV64 immediate decoder: combinational decode followed by STAGES elastic registers.
// Optional feature: IMMGEN_ZIMM_EN (handled inside immgen_pkg::decode_imm).
module imm_decode_pipe
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN_INSTR,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  OUT_IMM,
    output logic [2:0]       OUT_FMT,
    output logic             OUT_ILLEGAL,
    output logic [TAG_W-1:0] OUT_TAG
);

    localparam int unsigned PW = XLEN + 3 + 1 + TAG_W;

    imm_dec_t      dec;
    logic          unused_dec;
    logic [PW-1:0] pipe_data [STAGES+1];
    logic [STAGES:0] pipe_valid;
    logic [STAGES:0] pipe_ready;

    always_comb begin
        dec = decode_imm(IN_INSTR);
    end

    // Upper immediate bits are dropped when XLEN is 32.
    assign unused_dec = ^dec.imm;

    assign pipe_data[0]       = {dec.imm[XLEN-1:0], dec.fmt, dec.illegal, IN_TAG};
    assign pipe_valid[0]      = IN_VALID && !FLUSH;
    assign IN_READY           = !FLUSH && pipe_ready[0];
    assign pipe_ready[STAGES] = OUT_READY;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        imm_stage_reg #(
            .W(PW)
        ) u_stage (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .flush_i    (FLUSH),
            .in_valid_i (pipe_valid[g]),
            .in_ready_o (pipe_ready[g]),
            .in_data_i  (pipe_data[g]),
            .out_valid_o(pipe_valid[g+1]),
            .out_ready_i(pipe_ready[g+1]),
            .out_data_o (pipe_data[g+1])
        );
    end

    assign OUT_VALID   = pipe_valid[STAGES];
    assign OUT_IMM     = pipe_data[STAGES][PW-1 -: XLEN];
    assign OUT_FMT     = pipe_data[STAGES][TAG_W+1 +: 3];
    assign OUT_ILLEGAL = pipe_data[STAGES][TAG_W];
    assign OUT_TAG     = pipe_data[STAGES][TAG_W-1:0];

endmodule
